// File: rtl/fetch_queue.sv
// Fetch queue: buffers tagged fetch bundles in a circular store
// and presents the oldest entries to decode each cycle.
module fetch_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_pc,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0] in_num,
    input  logic [32*FETCH_WIDTH-1:0]        in_instr,
    input  logic                             in_tlb_refill,
    input  logic                             in_tlb_invalid,
    input  logic                             in_tlb_modified,
    output logic [ISSUE_WIDTH-1:0]           out_valid,
    output logic [32*ISSUE_WIDTH-1:0]        out_pc,
    output logic [32*ISSUE_WIDTH-1:0]        out_pcplus4,
    output logic [32*ISSUE_WIDTH-1:0]        out_instr,
    output logic [4*ISSUE_WIDTH-1:0]         out_exc,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0] out_accept,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - FETCH_WIDTH);
    localparam logic [CW-1:0] FW_C    = CW'(FETCH_WIDTH);
    localparam logic [CW-1:0] IW_C    = CW'(ISSUE_WIDTH);

    // pcplus4 is always pc + 4, so it is derived on read
    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];
    logic [3:0]    r_exc   [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_fault;
    logic          w_push;
    logic [3:0]    w_exc;
    logic [CW-1:0] w_num;
    logic [CW-1:0] w_npush;
    logic [CW-1:0] w_avail;
    logic [CW-1:0] w_acc;
    logic [CW-1:0] w_npop;
    logic [PW-1:0] w_idx;

    assign w_fault  = (|in_pc[1:0]) | in_tlb_refill
                    | in_tlb_invalid | in_tlb_modified;
    assign w_exc    = {in_tlb_modified, in_tlb_refill,
                       in_tlb_invalid, |in_pc[1:0]};
    assign in_ready = (r_count <= FULL_TH);
    assign w_push   = in_valid & in_ready & ~flush;
    assign w_num    = (CW'(in_num) > FW_C) ? FW_C : CW'(in_num);
    assign w_npush  = !w_push ? '0 : (w_fault ? CW'(1) : w_num);
    assign w_avail  = (r_count > IW_C) ? IW_C : r_count;
    assign w_acc    = CW'(out_accept);
    assign w_npop   = (w_acc > w_avail) ? w_avail : w_acc;
    assign count    = r_count;

    // Write accepted slots at the tail; a faulting bundle yields one entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (CW'(i) < w_npush) begin
                r_pc[r_tail + PW'(i)]    <= in_pc + 32'(4 * i);
                r_instr[r_tail + PW'(i)] <= w_fault ? 32'd0
                                          : in_instr[32*i +: 32];
                r_exc[r_tail + PW'(i)]   <= w_fault ? w_exc : 4'd0;
            end
        end
    end

    // Pointer and occupancy update; reset and flush empty the queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_npop);
            r_tail  <= r_tail + PW'(w_npush);
            r_count <= r_count + w_npush - w_npop;
        end
    end

    // Present the oldest entries; invalid slots read as zero
    always_comb begin
        out_valid   = '0;
        out_pc      = '0;
        out_pcplus4 = '0;
        out_instr   = '0;
        out_exc     = '0;
        w_idx       = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_count > CW'(k)) begin
                out_valid[k]          = 1'b1;
                out_pc[32*k +: 32]      = r_pc[w_idx];
                out_pcplus4[32*k +: 32] = r_pc[w_idx] + 32'd4;
                out_instr[32*k +: 32]   = r_instr[w_idx];
                out_exc[4*k +: 4]       = r_exc[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic
// checked each cycle against a queue-based reference model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] in_pc;
    logic [1:0]  in_num;
    logic [63:0] in_instr;
    logic        in_tlb_refill, in_tlb_invalid, in_tlb_modified;
    logic [1:0]  out_valid;
    logic [63:0] out_pc, out_pcplus4, out_instr;
    logic [7:0]  out_exc;
    logic [1:0]  out_accept;
    logic [3:0]  count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  exc;
    } ent_t;

    ent_t mq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 0;

    fetch_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_num(in_num), .in_instr(in_instr),
        .in_tlb_refill(in_tlb_refill),
        .in_tlb_invalid(in_tlb_invalid),
        .in_tlb_modified(in_tlb_modified),
        .out_valid(out_valid), .out_pc(out_pc),
        .out_pcplus4(out_pcplus4), .out_instr(out_instr),
        .out_exc(out_exc), .out_accept(out_accept), .count(count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: compare visible state with the model, then advance the
    // model by what the coming clock edge will do.
    always @(negedge clk) begin
        int sz, n;
        logic [31:0] p4;
        ent_t e;
        sz = mq.size();
        if (mon_en) begin
            chk("count", 64'(count), 64'(sz));
            chk("in_ready", 64'(in_ready), 64'((8 - sz) >= 2));
            for (int k = 0; k < 2; k++) begin
                if (k < sz) begin
                    p4 = mq[k].pc + 32'd4;
                    chk("valid", 64'(out_valid[k]), 64'(1));
                    chk("pc", 64'(out_pc[32*k +: 32]), 64'(mq[k].pc));
                    chk("pcplus4", 64'(out_pcplus4[32*k +: 32]), 64'(p4));
                    chk("instr", 64'(out_instr[32*k +: 32]),
                        64'(mq[k].instr));
                    chk("exc", 64'(out_exc[4*k +: 4]), 64'(mq[k].exc));
                end else begin
                    chk("valid", 64'(out_valid[k]), 64'(0));
                    chk("idle_fields",
                        {out_pc[32*k +: 32] | out_pcplus4[32*k +: 32],
                         out_instr[32*k +: 32] | 32'(out_exc[4*k +: 4])},
                        64'(0));
                end
            end
        end
        if (reset || flush) begin
            mq.delete();
        end else begin
            n = int'(out_accept);
            if (n > sz) n = sz;
            if (n > 2) n = 2;
            repeat (n) void'(mq.pop_front());
            if (in_valid && (8 - sz) >= 2) begin
                if (in_pc[1:0] != 0 || in_tlb_refill ||
                    in_tlb_invalid || in_tlb_modified) begin
                    e.pc    = in_pc;
                    e.instr = 32'd0;
                    e.exc   = {in_tlb_modified, in_tlb_refill,
                               in_tlb_invalid, |in_pc[1:0]};
                    mq.push_back(e);
                end else begin
                    for (int i = 0; i < int'(in_num); i++) begin
                        e.pc    = in_pc + 32'(4 * i);
                        e.instr = in_instr[32*i +: 32];
                        e.exc   = 4'd0;
                        mq.push_back(e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, logic [31:0] pc, int num,
                         logic [31:0] a, logic [31:0] b,
                         bit rf, bit inv, bit md, int acc);
        in_valid        = v;
        in_pc           = pc;
        in_num          = 2'(num);
        in_instr        = {b, a};
        in_tlb_refill   = rf;
        in_tlb_invalid  = inv;
        in_tlb_modified = md;
        out_accept      = 2'(acc);
    endtask

    task automatic idle(int acc);
        drive(0, 32'd0, 1, 32'd0, 32'd0, 0, 0, 0, acc);
    endtask

    initial begin
        logic [31:0] base, exp_pc;
        bit hold, rdy;
        reset = 1'b1;
        flush = 1'b0;
        idle(0);
        step();
        mon_en = 1;
        step();
        reset = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_data", out_pc | out_instr | 64'(out_exc), 64'(0));

        drive(1, 32'hBFC00000, 2, 32'h11111111, 32'h22222222,
              0, 0, 0, 0);
        step();
        idle(0);
        chk("first_valid", 64'(out_valid), 64'(2'b11));
        chk("first_pc", out_pc, {32'hBFC00004, 32'hBFC00000});
        chk("first_pcp4", out_pcplus4, {32'hBFC00008, 32'hBFC00004});
        chk("first_instr", out_instr, {32'h22222222, 32'h11111111});
        chk("first_count", 64'(count), 64'(2));
        idle(2);
        step();

        drive(1, 32'h80000002, 2, 32'hAAAA0001, 32'hAAAA0002,
              0, 0, 0, 0);
        step();
        idle(0);
        chk("mis_valid", 64'(out_valid), 64'(2'b01));
        chk("mis_exc", 64'(out_exc[3:0]), 64'(4'b0001));
        chk("mis_instr", 64'(out_instr[31:0]), 64'(0));
        chk("mis_pc", 64'(out_pc[31:0]), 64'(32'h80000002));
        drive(1, 32'h00001000, 2, 32'hBBBB0001, 32'hBBBB0002,
              1, 0, 0, 1);
        step();
        idle(0);
        chk("refill_count", 64'(count), 64'(1));
        chk("refill_exc", 64'(out_exc[3:0]), 64'(4'b0100));
        chk("refill_pc", 64'(out_pc[31:0]), 64'(32'h1000));
        idle(2);
        step();

        for (int j = 0; j < 4; j++) begin
            drive(1, 32'h4000 + 32'(8 * j), 2, 32'(j), 32'(j + 100),
                  0, 0, 0, 0);
            step();
        end
        idle(0);
        chk("full_count", 64'(count), 64'(8));
        chk("full_ready", 64'(in_ready), 64'(0));
        idle(1);
        step();
        chk("acc1_count", 64'(count), 64'(7));
        chk("acc1_ready", 64'(in_ready), 64'(0));
        step();
        chk("acc2_count", 64'(count), 64'(6));
        chk("acc2_ready", 64'(in_ready), 64'(1));
        idle(2);
        repeat (3) step();
        chk("drain_count", 64'(count), 64'(0));

        base = 32'hFFFFFFC0;
        drive(1, base, 2, 32'h5, 32'h6, 0, 0, 0, 2);
        step();
        for (int j = 1; j <= 20; j++) begin
            drive(1, base + 32'(8 * j), 2, 32'(j), 32'(j),
                  0, 0, 0, 2);
            step();
            exp_pc = base + 32'(8 * j);
            chk("steady_valid", 64'(out_valid), 64'(2'b11));
            chk("steady_pc", out_pc, {exp_pc + 32'd4, exp_pc});
        end
        idle(2);
        step();
        chk("steady_drain", 64'(count), 64'(0));

        drive(1, 32'h5000, 2, 32'h1, 32'h2, 0, 0, 0, 0);
        step();
        drive(1, 32'h5008, 2, 32'h3, 32'h4, 0, 0, 0, 0);
        step();
        drive(1, 32'h5011, 2, 32'h5, 32'h6, 0, 0, 0, 0);
        step();
        chk("pre_flush_count", 64'(count), 64'(5));
        flush = 1'b1;
        drive(1, 32'h6000, 2, 32'h7, 32'h8, 0, 0, 0, 2);
        step();
        flush = 1'b0;
        idle(0);
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_valid", 64'(out_valid), 64'(0));
        step();
        chk("flush_dropped", 64'(count), 64'(0));

        drive(1, 32'h7000, 1, 32'hC1, 32'hC2, 0, 0, 0, 0);
        step();
        chk("one_count", 64'(count), 64'(1));
        idle(2);
        step();
        idle(0);
        chk("under_count", 64'(count), 64'(0));
        chk("under_valid", 64'(out_valid), 64'(0));
        drive(1, 32'h7100, 2, 32'hD1, 32'hD2, 0, 0, 0, 0);
        step();
        idle(0);
        chk("after_under_valid", 64'(out_valid), 64'(2'b11));
        chk("after_under_pc", 64'(out_pc[31:0]), 64'(32'h7100));

        reset = 1'b1;
        flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        chk("rstflush_count", 64'(count), 64'(0));
        chk("rstflush_valid", 64'(out_valid), 64'(0));

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                in_valid        = ($urandom_range(0, 9) < 7);
                in_pc           = $urandom();
                if ($urandom_range(0, 15) != 0) in_pc[1:0] = 2'b00;
                in_num          = 2'($urandom_range(1, 2));
                in_instr        = {$urandom(), $urandom()};
                in_tlb_refill   = ($urandom_range(0, 19) == 0);
                in_tlb_invalid  = ($urandom_range(0, 19) == 0);
                in_tlb_modified = ($urandom_range(0, 19) == 0);
            end
            flush      = ($urandom_range(0, 49) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            out_accept = 2'($urandom_range(0, 3) % 3);
            rdy = in_ready;
            step();
            hold = in_valid && !rdy && !flush && !reset;
        end
        reset = 1'b0;
        flush = 1'b0;
        idle(2);
        repeat (6) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
